// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Turns an EX-stage branch/jump decision into a valid/ready redirect to fetch.
// It flushes IF/ID while the redirect is pending. After fetch accepts, it keeps
// IF flushed for DRAIN_CYCLES so that in-flight imem responses are discarded.
// Misaligned targets raise a one-cycle trap pulse instead of a redirect.
// Optional feature macro: BR_REDIRECT_CNT_EN. When it is defined, redirect_count
// counts accepted redirect handshakes. Otherwise redirect_count is tied to 0.
module branch_redirect_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            stall,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] ex_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush_if,
  output logic            flush_id,
  output logic            busy,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_tval,
  output logic [XLEN-1:0] misalign_epc,
  output logic [31:0]     redirect_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  // Drain window length (1..15) loaded when fetch accepts the redirect.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      drain_q, drain_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            exc_q, exc_d;
  logic            take;
  logic            handshake;

  // A resolved taken branch. EX contents are only trusted while IDLE.
  assign take      = ex_valid & jump_flag & ~stall;
  assign handshake = (state_q == S_REDIRECT) & redirect_ready;

  // Next-state and datapath latch decisions.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    epc_d   = epc_q;
    exc_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          if (jump_target[1:0] == 2'b00) begin
            pc_d    = jump_target;
            state_d = S_REDIRECT;
          end else begin
            exc_d  = 1'b1;
            tval_d = jump_target;
            epc_d  = ex_pc;
          end
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          drain_d = DRAIN_INIT;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave on the cycle the counter reaches 1 so DRAIN lasts exactly DRAIN_CYCLES.
        if (drain_q <= 4'd1) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched datapath registers; reset abandons any redirect in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      pc_q    <= RESET_PC;
      tval_q  <= '0;
      epc_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
    end
  end

  assign redirect_valid = (state_q == S_REDIRECT);
  assign flush_id       = (state_q == S_REDIRECT);
  assign flush_if       = (state_q != S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign redirect_pc    = pc_q;
  assign misalign_exc   = exc_q;
  assign misalign_tval  = tval_q;
  assign misalign_epc   = epc_q;

`ifdef BR_REDIRECT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count accepted handshakes only; wraps naturally at 32 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (handshake) cnt_d = cnt_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign redirect_count = cnt_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign redirect_count   = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_branch_redirect_ctrl;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, stall, jump_flag, redirect_ready;
  logic [31:0] jump_target, ex_pc;
  logic        redirect_valid, flush_if, flush_id, busy, misalign_exc;
  logic [31:0] redirect_pc, misalign_tval, misalign_epc, redirect_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a redirect is outstanding until accepted, then a drain window runs.
  bit          m_outstanding;
  int          m_drain_left;
  logic [31:0] m_pc, m_tval, m_epc, m_cnt;
  bit          m_exc;

  branch_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .jump_flag(jump_flag),
    .jump_target(jump_target), .ex_pc(ex_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .flush_if(flush_if),
    .flush_id(flush_id), .busy(busy), .misalign_exc(misalign_exc),
    .misalign_tval(misalign_tval), .misalign_epc(misalign_epc),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_outstanding = 0; m_drain_left = 0; m_pc = RPC;
    m_tval = '0; m_epc = '0; m_cnt = '0; m_exc = 0;
  endtask

  // Applies one clock edge of the specification's rules to the model.
  task automatic model_step();
    bit take;
    if (rst) begin
      model_reset();
      return;
    end
    take  = ex_valid && jump_flag && !stall;
    m_exc = 0;
    if (m_outstanding) begin
      if (redirect_ready) begin
        m_outstanding = 0;
        m_drain_left  = DRAIN;
        m_cnt         = m_cnt + 1;
      end
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end else if (take) begin
      if (jump_target % 4 == 0) begin
        m_outstanding = 1;
        m_pc          = jump_target;
      end else begin
        m_exc  = 1;
        m_tval = jump_target;
        m_epc  = ex_pc;
      end
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef BR_REDIRECT_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // One clock: the model advances at the edge, and the bench returns 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; jump_flag = 0; stall = 0; redirect_ready = 0;
    jump_target = '0; ex_pc = '0;
  endtask

  task automatic drive_take(input logic [31:0] tgt, input logic [31:0] pc, input logic rdy);
    ex_valid = 1; jump_flag = 1; stall = 0; jump_target = tgt; ex_pc = pc; redirect_ready = rdy;
  endtask

  function automatic logic [4:0] obs();
    return {redirect_valid, flush_if, flush_id, busy, misalign_exc};
  endfunction

  task automatic do_reset();
    idle_inputs();
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== 5'b0 || redirect_pc !== RPC || misalign_tval !== 0 ||
        misalign_epc !== 0 || redirect_count !== 0) begin
      failures++;
      $display("FAIL reset_state: flags=%b pc=%h tval=%h epc=%h cnt=%0d, required flags=00000 pc=%h others 0",
               obs(), redirect_pc, misalign_tval, misalign_epc, redirect_count, RPC);
    end
    $display("reset: flags=%b pc=%h", obs(), redirect_pc);
  endtask

  // Takes a redirect with ready held high and checks the full timeline to IDLE.
  task automatic run_basic(input string name, input logic [31:0] tgt);
    drive_take(tgt, 32'h10, 1'b1);
    tick();
    ex_valid = 0; jump_flag = 0;
    checks++;
    if (obs() !== 5'b11110 || redirect_pc !== tgt) begin
      failures++;
      $display("FAIL %s_redirect: flags=%b pc=%h, required flags=11110 pc=%h", name, obs(), redirect_pc, tgt);
    end
    for (int i = 0; i < DRAIN; i++) begin
      tick();
      checks++;
      if (obs() !== 5'b01010) begin
        failures++;
        $display("FAIL %s_drain%0d: flags=%b, required 01010", name, i, obs());
      end
    end
    tick();
    checks++;
    if (obs() !== 5'b00000 || redirect_pc !== tgt) begin
      failures++;
      $display("FAIL %s_idle: flags=%b pc=%h, required flags=00000 pc=%h", name, obs(), redirect_pc, tgt);
    end
    redirect_ready = 0;
    $display("%s: target=%h redirect and drain done", name, tgt);
  endtask

  task automatic test_basic();
    run_basic("basic", 32'h0000_0100);
  endtask

  task automatic test_backpressure();
    drive_take(32'h0000_0100, 32'h20, 1'b0);
    tick();
    drive_take(32'h0000_0200, 32'h24, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs() !== 5'b11110 || redirect_pc !== 32'h100) begin
        failures++;
        $display("FAIL backpressure_hold%0d: flags=%b pc=%h, required flags=11110 pc=00000100", i, obs(), redirect_pc);
      end
      if (i < 4) tick();
    end
    idle_inputs();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    checks++;
    if (obs() !== 5'b01010) begin
      failures++;
      $display("FAIL backpressure_drain: flags=%b, required 01010", obs());
    end
    repeat (DRAIN) tick();
    checks++;
    if (obs() !== 5'b00000 || redirect_pc !== 32'h100) begin
      failures++;
      $display("FAIL backpressure_idle: flags=%b pc=%h, required flags=00000 pc=00000100", obs(), redirect_pc);
    end
    $display("backpressure: held 5 cycles, second take ignored");
  endtask

  task automatic test_stall();
    drive_take(32'h0000_0180, 32'h30, 1'b1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== 5'b00000) begin
        failures++;
        $display("FAIL stall_hold%0d: flags=%b, required 00000", i, obs());
      end
    end
    stall = 0;
    tick();
    idle_inputs();
    redirect_ready = 1;
    checks++;
    if (obs() !== 5'b11110 || redirect_pc !== 32'h180) begin
      failures++;
      $display("FAIL stall_release: flags=%b pc=%h, required flags=11110 pc=00000180", obs(), redirect_pc);
    end
    repeat (DRAIN + 1) tick();
    redirect_ready = 0;
    $display("stall: redirect one cycle after stall release");
  endtask

  task automatic test_misaligned();
    drive_take(32'h0000_0102, 32'h0000_0040, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (obs() !== 5'b00001 || misalign_tval !== 32'h102 || misalign_epc !== 32'h40) begin
      failures++;
      $display("FAIL misaligned_pulse: flags=%b tval=%h epc=%h, required flags=00001 tval=00000102 epc=00000040",
               obs(), misalign_tval, misalign_epc);
    end
    tick();
    checks++;
    if (obs() !== 5'b00000 || misalign_tval !== 32'h102 || misalign_epc !== 32'h40) begin
      failures++;
      $display("FAIL misaligned_after: flags=%b tval=%h epc=%h, required flags=00000 tval=00000102 epc=00000040",
               obs(), misalign_tval, misalign_epc);
    end
    $display("misaligned: target=00000102 trapped");
  endtask

  task automatic test_reset_mid();
    drive_take(32'h0000_0180, 32'h50, 1'b1);
    tick();
    idle_inputs();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (obs() !== 5'b00000 || redirect_pc !== RPC || misalign_tval !== 0 ||
        misalign_epc !== 0 || redirect_count !== 0) begin
      failures++;
      $display("FAIL reset_mid: flags=%b pc=%h tval=%h epc=%h cnt=%0d, required all 0 pc=%h",
               obs(), redirect_pc, misalign_tval, misalign_epc, redirect_count, RPC);
    end
    tick();
    rst = 0;
    tick();
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_mid_release: flags=%b, required 00000", obs());
    end
    $display("reset_mid: asynchronous reset during drain");
    run_basic("post_reset", 32'h0000_0300);
  endtask

  task automatic test_counter();
    do_reset();
    for (int i = 0; i < 3; i++) run_basic("count", 32'h0000_1000 + 32'(i * 4));
    drive_take(32'h0000_0103, 32'h60, 1'b1);
    tick();
    idle_inputs();
    tick();
    checks++;
`ifdef BR_REDIRECT_CNT_EN
    if (redirect_count !== 32'd3) begin
      failures++;
      $display("FAIL counter: count=%0d, required 3", redirect_count);
    end
`else
    if (redirect_count !== 32'd0) begin
      failures++;
      $display("FAIL counter: count=%0d, required 0", redirect_count);
    end
`endif
    $display("counter: count=%0d", redirect_count);
  endtask

  task automatic test_random();
    logic [4:0] exp_flags;
    for (int n = 0; n < 400; n++) begin
      ex_valid       = ($urandom_range(0, 3) != 0);
      jump_flag      = ($urandom_range(0, 2) == 0);
      stall          = ($urandom_range(0, 4) == 0);
      redirect_ready = $urandom_range(0, 1) == 1;
      jump_target    = {$urandom_range(0, 32'hFFFF), 14'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) jump_target[1:0] = 2'($urandom_range(1, 3));
      ex_pc          = $urandom;
      tick();
      exp_flags = {m_outstanding, (m_outstanding || m_drain_left > 0), m_outstanding,
                   (m_outstanding || m_drain_left > 0), m_exc};
      checks++;
      if (obs() !== exp_flags || redirect_pc !== m_pc || misalign_tval !== m_tval ||
          misalign_epc !== m_epc || redirect_count !== exp_count()) begin
        failures++;
        $display("FAIL random_%0d: flags=%b pc=%h tval=%h epc=%h cnt=%0d, required flags=%b pc=%h tval=%h epc=%h cnt=%0d",
                 n, obs(), redirect_pc, misalign_tval, misalign_epc, redirect_count,
                 exp_flags, m_pc, m_tval, m_epc, exp_count());
      end
    end
    idle_inputs();
    $display("random: 400 cycles compared, count=%0d", redirect_count);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_misaligned();
    test_reset_mid();
    test_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
